fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program sequencer for the 9-bit processor. Owns the PC, the start/done handshake with the testbench, and the two-cycle sequencing of loads.
- Sits between the instruction ROM and the instruction decoder/datapath.
- Consumes the decoder's Branch and load indications. Produces the PC and a single execute-enable that gates every register-file, data-memory and flag write.
- Resolves branch targets through a 32-entry absolute-target lookup table.

Parameters:
- PC_W, 10, PC and program-address width.
- CNT_W, 16, width of the cycle and instruction counters.

Ports:
- Clk  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin program; sampled in IDLE and DONE only.
- ProgBase  in  PC_W  first instruction address; latched when Start is accepted.
- ProgLast  in  PC_W  address of the last instruction; latched when Start is accepted.
- InstIn  in  9  instruction at the current PC (combinational ROM read).
- Branch  in  1  branch-taken from the decoder, already qualified by its flag.
- IsLoad  in  1  current instruction is a load (decoder MemToReg).
- PC  out  PC_W  current instruction address.
- ExecEn  out  1  datapath writes and flag updates are permitted this cycle.
- Done  out  1  program complete; held until the next accepted Start.
- CycleCnt  out  CNT_W  cycles spent in RUN plus LOAD_WAIT, saturating.
- InstCnt  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (asynchronous, any state, including mid-program): state=IDLE; PC=0, ExecEn=0, Done=0, CycleCnt=0, InstCnt=0; latched base and last addresses = 0.
- States: IDLE, RUN, LOAD_WAIT, DONE. State encoding is a 2-bit enum.
- IDLE: ExecEn=0, PC held. Start=1 -> PC<=ProgBase, latch ProgLast, clear both counters, go to RUN on the next edge.
- RUN with IsLoad=0:
  - ExecEn=1 (combinational from state and IsLoad). The instruction retires this cycle; InstCnt+1.
  - Next PC: if Branch=1, PC<=LUT[InstIn[4:0]] and stay in RUN.
  - Else if PC==ProgLast, go to DONE with PC held.
  - Else PC<=PC+1, wrapping modulo 2^PC_W.
- RUN with IsLoad=1: ExecEn=0, PC held, go to LOAD_WAIT. This covers the one-cycle data-memory read latency.
- LOAD_WAIT: ExecEn=1 and the load retires (InstCnt+1). Next PC follows the same rules as RUN with Branch treated as 0; return to RUN or go to DONE. IsLoad is ignored in this state.
- DONE: Done=1, ExecEn=0, PC and counters frozen. Start=1 -> restart exactly as from IDLE, Done<=0 on the same edge.
- Start while in RUN or LOAD_WAIT is ignored.
- Branch when PC==ProgLast: the branch wins and the program continues.
- Branch=1 together with IsLoad=1 is illegal and not generated by the decoder; the load path takes priority.
- CycleCnt increments every cycle in RUN or LOAD_WAIT. Both counters saturate at all-ones and never wrap.
- Latency: a taken branch redirects the PC on the next edge. No delay slot and no instruction is fetched twice.
- Counters reflect the last program until the next accepted Start.

Decomposition:
- Shared package proc_pkg holds:
  - the seq_state_t enum;
  - the 32-entry branch-target constant array BR_TARGETS, PC_W wide, written per program by the assembler flow;
  - the opcode constants OP_LOAD=4'd15 and OP_BEQ=4'd0, for benches.
- One sub-module, branch_lut: combinational, 5-bit index in, PC_W target out, reads BR_TARGETS.

Test Plan:
- Straight-line run: ProgBase=0, ProgLast=3, no branches or loads, Start pulse -> PC goes 0,1,2,3. Done=1 on the 5th cycle after Start, CycleCnt=4, InstCnt=4.
- Load stall: instruction at PC=1 has IsLoad=1 -> ExecEn=0 at PC=1 for one cycle, then 1. PC stays at 1 for two cycles. ProgLast=2 gives CycleCnt=4, InstCnt=3.
- Taken branch: BR_TARGETS[5]=10'd8, InstIn=9'b0000_00101 with Branch=1 at PC=2 -> next PC=8. An untaken branch (Branch=0) gives PC=3.
- Branch at ProgLast: PC=ProgLast=4, Branch=1, target 1 -> Done stays 0 and PC=1.
- Reset mid-program: assert Reset in LOAD_WAIT -> PC, counters, ExecEn and Done are 0 immediately (asynchronous). After release the block stays IDLE until Start.
- Restart from DONE and saturation:
  - Start in DONE -> Done drops on that edge and PC=ProgBase.
  - A 70000-cycle loop (branch to self) -> CycleCnt=16'hFFFF and InstCnt=16'hFFFF, both held.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor: sequencer states, branch-target table
// and the opcode constants used by benches.
package proc_pkg;

  localparam int PROC_PC_W = 10;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_LOAD_WAIT = 2'd2,
    S_DONE      = 2'd3
  } seq_state_t;

  // Absolute branch targets, regenerated per program by the assembler flow.
  localparam logic [PROC_PC_W-1:0] BR_TARGETS [32] = '{
    10'd12,  10'd40,  10'd100, 10'd3,   10'd512, 10'd8,   10'd1,   10'd20,
    10'd1023,10'd64,  10'd200, 10'd7,   10'd300, 10'd2,   10'd15,  10'd999,
    10'd33,  10'd700, 10'd5,   10'd128, 10'd256, 10'd11,  10'd900, 10'd4,
    10'd600, 10'd9,   10'd450, 10'd17,  10'd800, 10'd6,   10'd1000,10'd30
  };

  localparam logic [3:0] OP_LOAD = 4'd15;
  localparam logic [3:0] OP_BEQ  = 4'd0;

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: 5-bit immediate from the instruction selects
// an absolute PC from the assembler-generated table.
module branch_lut
  import proc_pkg::*;
#(
  parameter int PC_W = PROC_PC_W
) (
  input  logic [4:0]      idx,
  output logic [PC_W-1:0] target
);

  assign target = PC_W'(BR_TARGETS[idx]);

endmodule

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, the Start/Done handshake, the two-cycle load
// sequencing and the saturating cycle/instruction counters.
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W  = PROC_PC_W,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  ProgBase,
  input  logic [PC_W-1:0]  ProgLast,
  input  logic [8:0]       InstIn,
  input  logic             Branch,
  input  logic             IsLoad,
  output logic [PC_W-1:0]  PC,
  output logic             ExecEn,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstCnt
);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]  br_target;
  logic             unused_opcode;

  // Only the 5-bit immediate matters here; the opcode is decoded elsewhere.
  assign unused_opcode = ^InstIn[8:5];

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .idx    (InstIn[4:0]),
    .target (br_target)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    cyc_d   = cyc_q;
    inst_d  = inst_q;
    ExecEn  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          pc_d    = ProgBase;
          last_d  = ProgLast;
          cyc_d   = '0;
          inst_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        cyc_d = sat_inc(cyc_q);
        if (IsLoad) begin
          // Hold the PC one extra cycle to cover the data-memory read latency.
          state_d = S_LOAD_WAIT;
        end else begin
          ExecEn = 1'b1;
          inst_d = sat_inc(inst_q);
          if (Branch)              pc_d    = br_target;
          else if (pc_q == last_q) state_d = S_DONE;
          else                     pc_d    = pc_q + PC_W'(1);
        end
      end

      S_LOAD_WAIT: begin
        ExecEn = 1'b1;
        cyc_d  = sat_inc(cyc_q);
        inst_d = sat_inc(inst_q);
        if (pc_q == last_q) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      cyc_q   <= '0;
      inst_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
    end
  end

  assign PC       = pc_q;
  assign Done     = (state_q == S_DONE);
  assign CycleCnt = cyc_q;
  assign InstCnt  = inst_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: an instruction-level program walker predicts the per-cycle
// PC/ExecEn trace and final counters; directed programs pin it with literal values.
module tb_fetch_sequencer;
  import proc_pkg::*;

  localparam int TRACE_CAP = 200;

  typedef struct packed {
    logic [9:0] pc;
    logic       exec;
  } step_t;

  logic        Clk, Reset, Start, Branch, IsLoad;
  logic [9:0]  ProgBase, ProgLast, PC;
  logic [8:0]  InstIn;
  logic        ExecEn, Done;
  logic [15:0] CycleCnt, InstCnt;

  logic [8:0]  rom_inst [1024];
  logic        rom_load [1024];
  logic        rom_br   [1024];
  step_t       tr[$];
  logic [9:0]  pc_log [TRACE_CAP+2];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          in_done  = 0;
  bit          fin;

  fetch_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .ProgBase (ProgBase),
    .ProgLast (ProgLast),
    .InstIn   (InstIn),
    .Branch   (Branch),
    .IsLoad   (IsLoad),
    .PC       (PC),
    .ExecEn   (ExecEn),
    .Done     (Done),
    .CycleCnt (CycleCnt),
    .InstCnt  (InstCnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Walk the program at instruction level; one entry per clock the block spends running.
  function automatic bit build_trace(input logic [9:0] base, input logic [9:0] last);
    logic [9:0] pc;
    pc = base;
    tr.delete();
    while (tr.size() < TRACE_CAP) begin
      if (rom_load[pc]) begin
        tr.push_back(step_t'{pc, 1'b0});
        tr.push_back(step_t'{pc, 1'b1});
        if (pc == last) return 1'b1;
        pc = pc + 10'd1;
      end else begin
        tr.push_back(step_t'{pc, 1'b1});
        if (rom_br[pc])       pc = BR_TARGETS[rom_inst[pc][4:0]];
        else if (pc == last)  return 1'b1;
        else                  pc = pc + 10'd1;
      end
    end
    return 1'b0;
  endfunction

  task automatic drive_rom();
    InstIn = rom_inst[PC];
    IsLoad = rom_load[PC];
    Branch = rom_br[PC];
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) begin
      rom_inst[i] = '0;
      rom_load[i] = 1'b0;
      rom_br[i]   = 1'b0;
    end
  endtask

  // Called away from a clock edge.
  task automatic apply_reset();
    Reset = 1'b1;
    Start = 1'b0;
    #1;
    check("rst_pc",   PC,       0);
    check("rst_exec", ExecEn,   0);
    check("rst_done", Done,     0);
    check("rst_cyc",  CycleCnt, 0);
    check("rst_inst", InstCnt,  0);
    @(negedge Clk);
    @(negedge Clk);
    Reset  = 1'b0;
    in_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      Start  = 1'b0;
      IsLoad = 1'($urandom);
      Branch = 1'($urandom);
      #1;
      check("idle_pc",   PC,     0);
      check("idle_exec", ExecEn, 0);
      check("idle_done", Done,   0);
      check("idle_cyc",  CycleCnt, 0);
    end
  endtask

  task automatic run_prog(input logic [9:0] base, input logic [9:0] last,
                          input int limit, output bit finished);
    bit   done_m;
    int   n;
    int   retired;
    done_m = build_trace(base, last);
    n = (tr.size() < limit) ? tr.size() : limit;
    finished = done_m && (limit >= tr.size());

    @(negedge Clk);
    Start    = 1'b1;
    ProgBase = base;
    ProgLast = last;
    InstIn   = 9'($urandom);
    IsLoad   = 1'($urandom);
    Branch   = 1'b0;
    #1;
    check("start_exec", ExecEn, 0);
    check("start_done", Done,   {31'd0, in_done});

    retired = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Start    = ($urandom_range(0, 3) == 0);
      ProgBase = 10'($urandom);
      ProgLast = 10'($urandom);
      drive_rom();
      #1;
      if (i < TRACE_CAP + 2) pc_log[i] = PC;
      check("run_pc",   PC,       {22'd0, tr[i].pc});
      check("run_exec", ExecEn,   {31'd0, tr[i].exec});
      check("run_done", Done,     0);
      check("run_cyc",  CycleCnt, i);
      check("run_inst", InstCnt,  retired);
      if (tr[i].exec) retired++;
    end

    if (finished) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge Clk);
        Start = 1'b0;
        drive_rom();
        #1;
        check("done_flag", Done,     1);
        check("done_exec", ExecEn,   0);
        check("done_pc",   PC,       {22'd0, last});
        check("done_cyc",  CycleCnt, n);
        check("done_inst", InstCnt,  retired);
      end
      in_done = 1'b1;
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Branch = 1'b0; IsLoad = 1'b0;
    ProgBase = '0; ProgLast = '0; InstIn = '0;
    clear_rom();
    #2;
    apply_reset();

    // Straight line 0..3.
    run_prog(10'd0, 10'd3, TRACE_CAP, fin);
    check("line_fin",  fin, 1);
    check("line_pc3",  pc_log[3], 3);
    check("line_cyc",  CycleCnt, 4);
    check("line_inst", InstCnt,  4);

    // Load at PC=1, restarted from DONE.
    rom_load[1] = 1'b1;
    rom_inst[1] = {OP_LOAD, 5'd0};
    run_prog(10'd0, 10'd2, TRACE_CAP, fin);
    check("load_restart_pc", pc_log[0], 0);
    check("load_hold",  pc_log[2], 1);
    check("load_cyc",   CycleCnt, 4);
    check("load_inst",  InstCnt,  3);

    // Taken and untaken branch at PC=2 through entry 5.
    clear_rom();
    rom_inst[2] = 9'b0000_00101;
    rom_br[2]   = 1'b1;
    run_prog(10'd0, 10'd9, TRACE_CAP, fin);
    check("br_taken", pc_log[3], 8);
    check("br_cyc",   CycleCnt, 5);
    rom_br[2] = 1'b0;
    run_prog(10'd0, 10'd9, TRACE_CAP, fin);
    check("br_untaken", pc_log[3], 3);

    // Branch at ProgLast (entry 6 -> 1) keeps running; reset lands in LOAD_WAIT.
    clear_rom();
    rom_load[2] = 1'b1;
    rom_inst[4] = {OP_BEQ, 5'd6};
    rom_br[4]   = 1'b1;
    run_prog(10'd0, 10'd4, 8, fin);
    check("last_br_pc4", pc_log[5], 4);
    check("last_br_pc1", pc_log[6], 1);
    @(posedge Clk);
    #2;
    check("lw_pc",   PC,     2);
    check("lw_exec", ExecEn, 1);
    apply_reset();

    // Self-loop at 20 (entry 7) long enough to saturate both counters.
    clear_rom();
    rom_inst[20] = {OP_BEQ, 5'd7};
    rom_br[20]   = 1'b1;
    run_prog(10'd20, 10'd20, 10, fin);
    for (int k = 0; k < 70000; k++) begin
      @(negedge Clk);
      Start = 1'b0;
      drive_rom();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      drive_rom();
      #1;
      check("sat_cyc",  CycleCnt, 16'hFFFF);
      check("sat_inst", InstCnt,  16'hFFFF);
      check("sat_pc",   PC,       20);
      check("sat_done", Done,     0);
    end
    @(posedge Clk);
    #2;
    apply_reset();

    // Random programs; runaway programs are cut off with an asynchronous reset.
    for (int p = 0; p < 25; p++) begin
      logic [9:0] base, last;
      for (int i = 0; i < 1024; i++) begin
        int r;
        r = $urandom_range(0, 99);
        rom_load[i] = (r < 15);
        rom_br[i]   = (r >= 15 && r < 20);
        if (r < 15)      rom_inst[i] = {OP_LOAD, 5'($urandom)};
        else if (r < 20) rom_inst[i] = {OP_BEQ, 5'($urandom)};
        else             rom_inst[i] = 9'($urandom);
      end
      base = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(1012, 1023))
                                         : 10'($urandom_range(0, 40));
      last = base + 10'($urandom_range(0, 20));
      run_prog(base, last, TRACE_CAP, fin);
      if (!fin) begin
        @(posedge Clk);
        #2;
        apply_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
